// File: rtl/pwm_duty_capture_pkg.sv
// pwm_duty_capture_pkg: shared constants for the PWM duty capture block.
// Used by the capture top, its divider and the bench.
`timescale 1ns/1ps
package pwm_duty_capture_pkg;

    localparam int DUTY_W      = 8;
    // Capture cycle to duty_valid visible, in clk cycles.
    localparam int DIV_LATENCY = 9;

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

endpackage

// File: rtl/pwm_duty_capture_divider.sv
// duty_divider: restoring divider, (dividend_h << 8) / divisor, 1 bit/cycle.
// Ports: start/dividend_h/divisor in; busy, done (last step), q (clamped).
`timescale 1ns/1ps
module duty_divider
    import pwm_duty_capture_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic [CNT_W-1:0]  dividend_h,
    input  logic [CNT_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] q
);

    localparam logic [2:0] LAST_STEP = 3'(DUTY_W - 1);

    logic              busy_q, busy_d;
    logic [2:0]        step_q, step_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [DUTY_W-2:0] quo_q, quo_d;
    logic              ovf_q, ovf_d;

    logic [CNT_W:0]    rem_sh;
    logic              ge;
    logic [DUTY_W-1:0] quo_nx;

    // Low 8 dividend bits are zero, so each step just doubles the remainder.
    assign rem_sh = {rem_q, 1'b0};
    assign ge     = rem_sh >= {1'b0, div_q};
    assign quo_nx = {quo_q, ge};

    assign busy = busy_q;
    assign done = busy_q & (step_q == LAST_STEP);
    assign q    = ovf_q ? DUTY_MAX : quo_nx;

    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        rem_d  = rem_q;
        div_d  = div_q;
        quo_d  = quo_q;
        ovf_d  = ovf_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            rem_d  = ge ? CNT_W'(rem_sh - {1'b0, div_q})
                        : rem_sh[CNT_W-1:0];
            quo_d  = quo_nx[DUTY_W-2:0];
            step_d = step_q + 3'd1;
            if (done) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            rem_d  = dividend_h;
            div_d  = divisor;
            // High time never reaches the period; clamp defensively.
            ovf_d  = dividend_h >= divisor;
            quo_d  = '0;
            step_d = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            quo_q  <= quo_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures period and 8-bit duty of an async PWM line.
// Ports: clk, rst, pwm_in -> duty, period, duty_valid (pulse), stuck.
`timescale 1ns/1ps
module pwm_duty_capture
    import pwm_duty_capture_pkg::*;
#(
    parameter int FREQ_CLK    = 100_000_000,
    parameter int CNT_W       = 20,
    parameter int TIMEOUT     = FREQ_CLK / 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              duty_valid,
    output logic              stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic [CNT_W-1:0]       cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0]       cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0]       per_pend_q, per_pend_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic                   armed_q, armed_d;
    logic                   stuck_q, stuck_d;
    logic                   valid_q, valid_d;

    logic                   s, rise, timeout, capture;
    logic                   div_busy, div_done;
    logic [DUTY_W-1:0]      div_res;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_prev_q;
    // A rise in the same cycle keeps the line alive.
    assign timeout = (cnt_p_q == TO_CNT) & ~stuck_q & ~rise;
    assign capture = rise & armed_q & ~div_busy;

    duty_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .abort      (timeout),
        .start      (capture),
        .dividend_h (cnt_h_q),
        .divisor    (cnt_p_q),
        .busy       (div_busy),
        .done       (div_done),
        .q          (div_res)
    );

    always_comb begin
        cnt_p_d    = cnt_p_q;
        cnt_h_d    = cnt_h_q;
        per_pend_d = per_pend_q;
        period_d   = period_q;
        duty_d     = duty_q;
        armed_d    = armed_q;
        stuck_d    = stuck_q;
        valid_d    = 1'b0;

        if (rise) begin
            cnt_p_d = CNT_W'(1);
            cnt_h_d = CNT_W'(1);
            stuck_d = 1'b0;
            armed_d = 1'b1;
        end else begin
            if (cnt_p_q != CNT_MAX) cnt_p_d = cnt_p_q + CNT_W'(1);
            if (s && cnt_h_q != CNT_MAX) cnt_h_d = cnt_h_q + CNT_W'(1);
        end

        if (capture) per_pend_d = cnt_p_q;

        // Timeout outranks a finishing division.
        priority case (1'b1)
            timeout: begin
                stuck_d  = 1'b1;
                armed_d  = 1'b0;
                duty_d   = s ? DUTY_MAX : '0;
                period_d = '0;
                valid_d  = 1'b1;
            end
            div_done: begin
                duty_d   = div_res;
                period_d = per_pend_q;
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            s_prev_q   <= 1'b0;
            cnt_p_q    <= '0;
            cnt_h_q    <= '0;
            per_pend_q <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            armed_q    <= 1'b0;
            stuck_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_prev_q   <= s;
            cnt_p_q    <= cnt_p_d;
            cnt_h_q    <= cnt_h_d;
            per_pend_q <= per_pend_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            armed_q    <= armed_d;
            stuck_q    <= stuck_d;
            valid_q    <= valid_d;
        end
    end

    assign duty       = duty_q;
    assign period     = period_q;
    assign duty_valid = valid_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb_pwm_duty_capture: random and directed PWM stimulus against an
// event-level reference model of duty/period/stuck reporting.
`timescale 1ns/1ps
module tb_pwm_duty_capture;
    import pwm_duty_capture_pkg::*;

    localparam int CNT_W = 20;
    localparam int TO    = 1500;
    localparam int SYNC  = 2;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             pwm_in = 1'b0;
    logic [7:0]       duty;
    logic [CNT_W-1:0] period;
    logic             duty_valid;
    logic             stuck;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int               cyc;
        logic [7:0]       duty;
        logic [CNT_W-1:0] per;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    bit m_armed;
    int m_last_rise;
    int m_last_cap;
    int m_prev_high;

    pwm_duty_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .period     (period),
        .duty_valid (duty_valid),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (duty_valid !== 1'b0) obs_q.push_back('{cyc, duty, period});
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Rise of the synchronized line in cycle r; hi = high time following it.
    task automatic model_rise(input int r, input int hi);
        int n;
        int d;
        if (m_armed) begin
            n = r - m_last_rise;
            if (r - m_last_cap >= DIV_LATENCY) begin
                d = (m_prev_high * 256) / n;
                if (d > 255) d = 255;
                exp_q.push_back('{r + DIV_LATENCY, 8'(d), CNT_W'(n)});
                m_last_cap = r;
            end
        end
        m_armed     = 1'b1;
        m_last_rise = r;
        m_prev_high = hi;
    endtask

    task automatic model_timeout(input int d);
        exp_q.push_back('{m_last_rise + TO + 1, 8'(d), CNT_W'(0)});
        m_armed    = 1'b0;
        m_last_cap = -1000;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        m_armed     = 1'b0;
        m_last_cap  = -1000;
        m_last_rise = 0;
        m_prev_high = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_period(input int per, input int hi);
        @(negedge clk);
        pwm_in = 1'b1;
        model_rise(cyc + SYNC, hi);
        repeat (hi - 1) @(negedge clk);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (per - hi - 1) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_cyc"}, obs_q[i].cyc, exp_q[i].cyc);
            check_eq({tag, "_duty"}, obs_q[i].duty, exp_q[i].duty);
            check_eq({tag, "_period"}, obs_q[i].per, exp_q[i].per);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int  per;
        int  hi;
        int  r;
        real ofs;

        @(negedge clk);
        do_reset();
        check_eq("rst_duty", duty, 0);
        check_eq("rst_period", period, 0);
        check_eq("rst_valid", duty_valid, 0);
        check_eq("rst_stuck", stuck, 0);

        repeat (5) drive_period(100, 25);
        repeat (15) @(negedge clk);
        check_eq("p100_stuck", stuck, 0);
        check_eq("p100_duty", duty, 64);
        check_eq("p100_period", period, 100);
        compare_events("p100");

        do_reset();
        repeat (3) drive_period(256, 255);
        repeat (3) drive_period(1000, 1);
        repeat (15) @(negedge clk);
        check_eq("p1000_duty", duty, 0);
        check_eq("p1000_period", period, 1000);
        compare_events("p256_1000");

        do_reset();
        repeat (8) drive_period(6, 3);
        repeat (15) @(negedge clk);
        compare_events("p6");

        do_reset();
        repeat (6) begin
            per = int'($urandom_range(200, 4));
            hi  = int'($urandom_range(per - 1, 1));
            repeat (3) drive_period(per, hi);
        end
        repeat (15) @(negedge clk);
        compare_events("rand");

        do_reset();
        @(negedge clk);
        pwm_in = 1'b1;
        model_rise(cyc + SYNC, 0);
        repeat (TO + 10) @(negedge clk);
        check_eq("hold1_stuck", stuck, 1);
        model_timeout(255);
        repeat (200) @(negedge clk);
        check_eq("hold1_stuck_kept", stuck, 1);
        check_eq("hold1_duty", duty, 255);
        check_eq("hold1_period", period, 0);
        compare_events("hold1");

        do_reset();
        drive_period(20, 5);
        repeat (TO + 10) @(negedge clk);
        check_eq("hold0_stuck", stuck, 1);
        check_eq("hold0_duty", duty, 0);
        model_timeout(0);
        drive_period(40, 10);
        check_eq("rearm_stuck", stuck, 0);
        repeat (2) drive_period(40, 10);
        repeat (15) @(negedge clk);
        check_eq("rearm_duty", duty, 64);
        compare_events("hold0");

        do_reset();
        drive_period(100, 2);
        @(negedge clk);
        pwm_in = 1'b1;
        r = cyc + SYNC;
        model_rise(r, 2);
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        while (cyc < r + 3) @(negedge clk);
        do_reset();
        check_eq("rstmid_duty", duty, 0);
        check_eq("rstmid_period", period, 0);
        check_eq("rstmid_valid", duty_valid, 0);
        check_eq("rstmid_stuck", stuck, 0);
        repeat (20) @(negedge clk);
        repeat (3) drive_period(50, 10);
        repeat (15) @(negedge clk);
        compare_events("rst_mid");

        do_reset();
        ofs = 0.05 + 0.1 * real'($urandom_range(99, 0));
        #(ofs);
        repeat (6) begin
            pwm_in = 1'b1;
            #1500;
            pwm_in = 1'b0;
            #1500;
        end
        repeat (20) @(negedge clk);
        check_eq("async_count", obs_q.size(), 5);
        foreach (obs_q[i]) begin
            check_eq("async_duty",
                     (obs_q[i].duty == 8'd127 || obs_q[i].duty == 8'd128), 1);
            check_eq("async_period",
                     (obs_q[i].per >= 20'd299 && obs_q[i].per <= 20'd301), 1);
        end
        check_eq("async_nox", $isunknown({duty, period, duty_valid, stuck}), 0);
        obs_q.delete();
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
